// File: rtl/mux_chan_deserializer.sv
// Drives the select line of an upstream 2:1 bit mux and assembles one WIDTH-bit word
// per channel from its output. Optional MUX_DESER_CONTINUOUS_EN adds back-to-back capture with a stop input.
module mux_chan_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             sel,
  input  logic             mux_out,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic             valid,
  input  logic             ready,
`ifdef MUX_DESER_CONTINUOUS_EN
  input  logic             stop,
`endif
  output logic             busy
);

  localparam int unsigned CW = $clog2(2 * WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CAPTURE;
          sel_d   = 1'b0;
          cnt_d   = '0;
          sh_a_d  = '0;
          sh_b_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // The bit on mux_out belongs to the channel selected during the cycle just ending.
        if (sel_q) sh_b_d = {sh_b_q[WIDTH-2:0], mux_out};
        else       sh_a_d = {sh_a_q[WIDTH-2:0], mux_out};
        sel_d = ~sel_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
`ifdef MUX_DESER_CONTINUOUS_EN
          if (stop) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_CAPTURE;
            sel_d   = 1'b0;
            cnt_d   = '0;
            sh_a_d  = '0;
            sh_b_d  = '0;
          end
`else
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
    end
  end

  assign sel    = sel_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign data_a = sh_a_q;
  assign data_b = sh_b_q;

endmodule
